crypto_reg_map: RTL



---
 rtl/crypto_reg_map_pkg.sv | 41 ++++
 rtl/crypto_reg_map_apb_fsm.sv | 85 ++++++++
 rtl/crypto_reg_map.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/crypto_reg_map_pkg.sv
// Shared definitions for the crypto register map: register indices, bit positions, FSM states.
// Latency: n/a (definitions only). Backpressure: n/a.
// Build option KEY_LOCK_EN enables the sticky CTRL key-lock bit.
package crypto_reg_map_pkg;

  // Register index = paddr[4:1]
  localparam logic [3:0] IDX_ID       = 4'd0;
  localparam logic [3:0] IDX_CTRL     = 4'd1;
  localparam logic [3:0] IDX_STATUS   = 4'd2;
  localparam logic [3:0] IDX_IRQ_STAT = 4'd3;
  localparam logic [3:0] IDX_KEY0     = 4'd4;
  localparam logic [3:0] IDX_KEY1     = 4'd5;
  localparam logic [3:0] IDX_KEY2     = 4'd6;
  localparam logic [3:0] IDX_KEY3     = 4'd7;
  localparam logic [3:0] IDX_DIN0     = 4'd8;
  localparam logic [3:0] IDX_DIN1     = 4'd9;
  localparam logic [3:0] IDX_DOUT0    = 4'd10;
  localparam logic [3:0] IDX_DOUT1    = 4'd11;

  localparam int CTRL_START    = 0;
  localparam int CTRL_MODE     = 1;
  localparam int CTRL_IRQ_EN   = 2;
  localparam int CTRL_KEY_LOCK = 3;
  localparam int IRQ_DONE      = 0;

  localparam logic [15:0] ID_DEFAULT = 16'hC0A1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  // pstrb=0 updates only the low byte; the high byte keeps its old value.
  function automatic logic [15:0] apply_strb(input logic [15:0] old_val,
                                             input logic [15:0] new_val,
                                             input logic        strb);
    return strb ? new_val : {old_val[15:8], new_val[7:0]};
  endfunction

endpackage

// File: rtl/crypto_reg_map_apb_fsm.sv
// APB handshake FSM: latches the request at setup, counts wait states, raises pready for one cycle.
// Latency: pready high in access cycle WAIT_STATES+1. Backpressure: wait states; psel drop aborts.
// No build options.
module rm_apb_fsm
  import crypto_reg_map_pkg::*;
#(
  parameter int WAIT_STATES = 0
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        psel,
  input  logic        penable,
  input  logic        pwrite,
  input  logic        pstrb,
  input  logic [19:0] paddr,
  input  logic [15:0] pwdata,
  output logic        sample,
  output logic        commit,
  output logic        pready,
  output logic        req_write,
  output logic        req_strb,
  output logic [19:0] req_addr,
  output logic [15:0] req_wdata
);

  state_t      state;
  logic [3:0]  cnt;
  logic        lat_write;
  logic        lat_strb;
  logic [19:0] lat_addr;
  logic [15:0] lat_wdata;
  logic        setup_ph;
  logic        access_ph;

  assign setup_ph  = psel & ~penable;
  assign access_ph = psel & penable;

  // With zero wait states the response is registered at the setup edge, so the
  // request is taken straight from the bus while idle.
  assign req_write = (state == ST_IDLE) ? pwrite : lat_write;
  assign req_strb  = (state == ST_IDLE) ? pstrb  : lat_strb;
  assign req_addr  = (state == ST_IDLE) ? paddr  : lat_addr;
  assign req_wdata = (state == ST_IDLE) ? pwdata : lat_wdata;

  // cnt counts remaining access edges; the last one (cnt==1) registers the response.
  assign sample = ((state == ST_IDLE) && setup_ph && (WAIT_STATES == 0)) ||
                  ((state == ST_WAIT) && access_ph && (cnt == 4'd1));
  assign commit = (state == ST_RESP) && psel;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      pready    <= 1'b0;
      lat_write <= 1'b0;
      lat_strb  <= 1'b0;
      lat_addr  <= '0;
      lat_wdata <= '0;
    end else begin
      pready <= sample;
      case (state)
        ST_IDLE: begin
          if (setup_ph) begin
            lat_write <= pwrite;
            lat_strb  <= pstrb;
            lat_addr  <= paddr;
            lat_wdata <= pwdata;
            cnt       <= WAIT_STATES[3:0];
            state     <= (WAIT_STATES == 0) ? ST_RESP : ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (!psel) begin
            state <= ST_IDLE;
          end else if (access_ph) begin
            if (cnt == 4'd1) state <= ST_RESP;
            else             cnt   <= cnt - 4'd1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/crypto_reg_map.sv
// Crypto core register map behind the APB arbiter: decode, control/key/data registers, start and irq.
// Latency: pready in access cycle WAIT_STATES+1. Backpressure: wait states only; psel drop aborts.
// Build option KEY_LOCK_EN adds the sticky CTRL.KEY_LOCK bit.
module crypto_reg_map
  import crypto_reg_map_pkg::*;
#(
  parameter logic [19:0] BASE_ADDR   = 20'h00000,
  parameter int          WAIT_STATES = 0,
  parameter logic [15:0] ID_VALUE    = ID_DEFAULT
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        psel,
  input  logic        penable,
  input  logic        pwrite,
  input  logic        pstrb,
  input  logic [19:0] paddr,
  input  logic [15:0] pwdata,
  output logic [15:0] prdata,
  output logic        pready,
  output logic        pslverr,
  output logic [63:0] key,
  output logic [31:0] din,
  output logic        mode,
  output logic        start,
  input  logic        core_busy,
  input  logic        core_done,
  input  logic [31:0] dout,
  output logic        irq
);

  logic        sample;
  logic        commit;
  logic        req_write;
  logic        req_strb;
  logic [19:0] req_addr;
  logic [15:0] req_wdata;

  rm_apb_fsm #(.WAIT_STATES(WAIT_STATES)) u_fsm (
    .clk       (clk),
    .reset_n   (reset_n),
    .psel      (psel),
    .penable   (penable),
    .pwrite    (pwrite),
    .pstrb     (pstrb),
    .paddr     (paddr),
    .pwdata    (pwdata),
    .sample    (sample),
    .commit    (commit),
    .pready    (pready),
    .req_write (req_write),
    .req_strb  (req_strb),
    .req_addr  (req_addr),
    .req_wdata (req_wdata)
  );

  logic [3:0][15:0] key_q;
  logic [1:0][15:0] din_q;
  logic [31:0]      dout_q;
  logic             irq_en_q;
  logic             done_q;
  logic             key_lock;
  logic [3:0]       idx;
  logic             in_region;
  logic [15:0]      rd_val;
  logic             err;
  logic             wr_ok;
  logic             unused_addr_lsb;

  assign idx             = req_addr[4:1];
  assign in_region       = (req_addr[19:5] == BASE_ADDR[19:5]);
  assign unused_addr_lsb = req_addr[0];
  assign key             = key_q;
  assign din             = din_q;

  always_comb begin
    rd_val = '0;
    err    = 1'b0;
    case (idx)
      IDX_ID:       begin rd_val = ID_VALUE; err = req_write; end
      IDX_CTRL: begin
        rd_val = {12'b0, key_lock, irq_en_q, mode, 1'b0};
        err    = req_write & core_busy & req_wdata[CTRL_START];
      end
      IDX_STATUS:   begin rd_val = {15'b0, core_busy}; err = req_write; end
      IDX_IRQ_STAT: rd_val = {15'b0, done_q};
      IDX_KEY0, IDX_KEY1, IDX_KEY2, IDX_KEY3:
                    err = req_write ? (core_busy | key_lock) : 1'b1;
      IDX_DIN0:     begin rd_val = din_q[0]; err = req_write & core_busy; end
      IDX_DIN1:     begin rd_val = din_q[1]; err = req_write & core_busy; end
      IDX_DOUT0:    begin rd_val = dout_q[15:0];  err = req_write; end
      IDX_DOUT1:    begin rd_val = dout_q[31:16]; err = req_write; end
      default:      err = 1'b1;
    endcase
    if (!in_region) err = 1'b1;
    if (req_write || err) rd_val = '0;
  end

  // pslverr still holds the registered decode result while in RESP.
  assign wr_ok = commit & req_write & ~pslverr;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      key_q    <= '0;
      din_q    <= '0;
      dout_q   <= '0;
      mode     <= 1'b0;
      irq_en_q <= 1'b0;
      done_q   <= 1'b0;
      start    <= 1'b0;
      irq      <= 1'b0;
      prdata   <= '0;
      pslverr  <= 1'b0;
    end else begin
      prdata  <= sample ? rd_val : '0;
      pslverr <= sample ? err : 1'b0;
      start   <= wr_ok && (idx == IDX_CTRL) && req_wdata[CTRL_START];
      irq     <= done_q & irq_en_q;
      if (wr_ok) begin
        case (idx)
          IDX_CTRL: begin
            mode     <= req_wdata[CTRL_MODE];
            irq_en_q <= req_wdata[CTRL_IRQ_EN];
          end
          IDX_KEY0, IDX_KEY1, IDX_KEY2, IDX_KEY3:
            key_q[idx[1:0]] <= apply_strb(key_q[idx[1:0]], req_wdata, req_strb);
          IDX_DIN0, IDX_DIN1:
            din_q[idx[0]] <= apply_strb(din_q[idx[0]], req_wdata, req_strb);
          default: ;
        endcase
      end
      // A completion in the same cycle as a W1C keeps DONE set.
      if (core_done) begin
        done_q <= 1'b1;
        dout_q <= dout;
      end else if (wr_ok && (idx == IDX_IRQ_STAT) && req_wdata[IRQ_DONE]) begin
        done_q <= 1'b0;
      end
    end
  end

`ifdef KEY_LOCK_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      key_lock <= 1'b0;
    else if (wr_ok && (idx == IDX_CTRL) && req_wdata[CTRL_KEY_LOCK])
      key_lock <= 1'b1;
  end
`else
  assign key_lock = 1'b0;
`endif

endmodule
